// File: rtl/cbus_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cbus_rr_arbiter
//
// Purpose:
//   Round-robin arbiter that shares a single CBus memory port between NREQ
//   requesters (instruction fetch, data access and page-table walker by
//   default). Once a requester is granted, the arbiter stays locked on it
//   until it completes (ready & last) or drops its valid (abort). The
//   arbiter never registers request fields; it only steers them.
//
// Bus layouts (flattened into plain vectors so the ports stay simple):
//   Request (REQ_W = 83 bits)
//     [0]      valid
//     [1]      is_write
//     [33:2]   addr
//     [36:34]  size
//     [40:37]  strobe
//     [72:41]  data
//     [80:73]  len
//     [82:81]  burst
//   Response (RESP_W = 34 bits)
//     [0]      ready
//     [1]      last
//     [33:2]   data
//
// Ports:
//   clk       in   single clock, rising-edge state updates
//   reset     in   synchronous active-high reset
//   ireqs     in   NREQ requests, requester i at [i*REQ_W +: REQ_W]
//   iresps    out  NREQ responses, requester i at [i*RESP_W +: RESP_W]
//   oreq      out  request forwarded to memory
//   oresp     in   response from memory
//   busy      out  high while a transaction is granted
//   grant_id  out  index of the granted requester (meaningful while busy)
//   beat_cnt  out  ready beats accepted in the current transaction (sat. 255)
// ---------------------------------------------------------------------------
module cbus_rr_arbiter #(
  parameter  int NREQ   = 3,
  localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int REQ_W  = 83,
  localparam int RESP_W = 34
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ*REQ_W-1:0]    ireqs,
  output logic [NREQ*RESP_W-1:0]   iresps,
  output logic [REQ_W-1:0]         oreq,
  input  logic [RESP_W-1:0]        oresp,
  output logic                     busy,
  output logic [IDW-1:0]           grant_id,
  output logic [7:0]               beat_cnt
);

  localparam int REQ_VALID  = 0;
  localparam int RESP_READY = 0;
  localparam int RESP_LAST  = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [IDW-1:0]   r_last;
  logic [IDW-1:0]   w_nextLast;
  logic [IDW-1:0]   r_grant;
  logic [IDW-1:0]   w_nextGrant;
  logic [7:0]       r_beatCnt;
  logic [7:0]       w_nextBeatCnt;

  logic [NREQ-1:0]  w_valid;
  logic             w_anyValid;
  logic [IDW-1:0]   w_pick;
  int               w_dist;
  int               w_bestDist;
  logic [REQ_W-1:0] w_grantReq;
  logic             w_grantValid;
  logic             w_active;

  // Gather the valid bit of every requester.
  always_comb begin
    w_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_valid[i] = ireqs[i*REQ_W + REQ_VALID];
    end
  end

  // Round-robin pick: each requester's distance is how many slots after the
  // last winner it sits, so the nearest valid one after last wins and the
  // last winner itself comes at the very end of the rotation.
  always_comb begin
    w_pick     = '0;
    w_anyValid = 1'b0;
    w_dist     = 0;
    w_bestDist = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      w_dist = (i - int'(r_last) - 1 + 2*NREQ) % NREQ;
      if (w_valid[i] && (w_dist < w_bestDist)) begin
        w_bestDist = w_dist;
        w_pick     = IDW'(i);
        w_anyValid = 1'b1;
      end
    end
  end

  // Select the currently granted request.
  always_comb begin
    w_grantReq = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (r_grant == IDW'(i)) begin
        w_grantReq = ireqs[i*REQ_W +: REQ_W];
      end
    end
  end

  assign w_grantValid = w_grantReq[REQ_VALID];

  // State register. Reset abandons any transaction in flight without
  // touching the pointer from the grant, so the lowest valid index wins next.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_last    <= IDW'(NREQ - 1);
      r_grant   <= '0;
      r_beatCnt <= '0;
    end else begin
      r_state   <= w_nextState;
      r_last    <= w_nextLast;
      r_grant   <= w_nextGrant;
      r_beatCnt <= w_nextBeatCnt;
    end
  end

  // Next-state logic. Completion and abort both land in IDLE, which always
  // lasts a cycle because arbitration only happens from IDLE. An abort takes
  // precedence over any beat memory presents in that cycle.
  always_comb begin
    w_nextState   = r_state;
    w_nextLast    = r_last;
    w_nextGrant   = r_grant;
    w_nextBeatCnt = r_beatCnt;
    unique case (r_state)
      ST_IDLE: begin
        if (w_anyValid) begin
          w_nextState   = ST_BUSY;
          w_nextGrant   = w_pick;
          w_nextBeatCnt = '0;
        end
      end
      ST_BUSY: begin
        if (!w_grantValid) begin
          w_nextState = ST_IDLE;
          w_nextLast  = r_grant;
        end else if (oresp[RESP_READY]) begin
          if (r_beatCnt != 8'hFF) begin
            w_nextBeatCnt = r_beatCnt + 8'd1;
          end
          if (oresp[RESP_LAST]) begin
            w_nextState = ST_IDLE;
            w_nextLast  = r_grant;
          end
        end
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Output steering. Reset masks everything immediately, before the
  // synchronous reset has even taken effect on the state register.
  assign w_active = (r_state == ST_BUSY) && !reset;

  always_comb begin
    oreq   = '0;
    iresps = '0;
    if (w_active) begin
      oreq = w_grantReq;
      for (int i = 0; i < NREQ; i++) begin
        if ((r_grant == IDW'(i)) && w_grantValid) begin
          iresps[i*RESP_W +: RESP_W] = oresp;
        end
      end
    end
  end

  assign busy     = w_active;
  assign grant_id = r_grant;
  assign beat_cnt = r_beatCnt;

endmodule
